rd_result_fifo: RTL

Result-capture stage sitting directly downstream of the pipelined recursive-doubling carry-lookahead adder. Tracks which adder issue cycles carried real operands, aligns that valid flag with the adder's fixed pipeline latency, and queues each {carry, sum} result in a small FIFO drained by a ready/valid consumer. The adder cannot stall, so the block also issues a credit signal telling the operand source when it may safely issue.

---
 rtl/rd_result_fifo.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rd_result_fifo.sv
// -----------------------------------------------------------------------------
// rd_result_fifo
//
// Result-capture stage behind the pipelined recursive-doubling carry-lookahead
// adder. A LAT-deep valid pipe follows each issued operand pair through the
// adder, so the valid flag lines up with sum_in/carry_in. Each valid
// {carry, sum} result is then queued in a DEPTH-entry FIFO that a ready/valid
// consumer drains. The adder cannot stall, so issue_ok tells the operand
// source when a new issue is guaranteed to find room in the FIFO.
//
// Parameters:
//   WIDTH  adder operand/sum width
//   LAT    adder latency in clocks, operand edge to sum/carry valid (1..8)
//   DEPTH  FIFO entries, power of two (2..16)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   in_valid   operands presented to the adder this cycle are real
//   sum_in     adder sum output
//   carry_in   adder carry output
//   out_ready  consumer accepts the head entry this cycle
//   out_valid  FIFO non-empty
//   out_sum    head entry sum (0 when empty)
//   out_carry  head entry carry (0 when empty)
//   count      entries held
//   full       count == DEPTH
//   issue_ok   count + in-flight < DEPTH
//   overflow   sticky: a result was dropped
//   out_parity head entry parity (0 when empty), only with RD_RESULT_PARITY_EN
//
// Build option: define RD_RESULT_PARITY_EN to store an XOR parity bit of
// {carry, sum} with every entry and expose it on out_parity.
// -----------------------------------------------------------------------------
module rd_result_fifo #(
  parameter int WIDTH = 8,
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             issue_ok,
  output logic             overflow
`ifdef RD_RESULT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int IF_W  = $clog2(LAT + 1);
  localparam int SUM_W = CNT_W + IF_W;

  typedef struct packed {
`ifdef RD_RESULT_PARITY_EN
    logic             parity;
`endif
    logic             carry;
    logic [WIDTH-1:0] sum;
  } entry_t;

  logic [LAT-1:0]   vpipe_q,    vpipe_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             overflow_q, overflow_d;
  entry_t           mem_q [DEPTH];

  logic             wr_en, rd_en, do_wr, drop;
  logic [IF_W-1:0]  inflight;
  logic [SUM_W-1:0] pending;
  entry_t           wr_entry, head;

  // The oldest stage of the valid pipe is aligned with the adder's outputs.
  assign wr_en     = vpipe_q[LAT-1];
  assign out_valid = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  // A full FIFO is never empty, so a read in the same cycle frees the slot.
  assign rd_en     = out_valid & out_ready;
  assign do_wr     = wr_en & (~full | rd_en);
  assign drop      = wr_en & full & ~rd_en;

  always_comb begin
    wr_entry       = '0;
    wr_entry.sum   = sum_in;
    wr_entry.carry = carry_in;
`ifdef RD_RESULT_PARITY_EN
    wr_entry.parity = ^{carry_in, sum_in};
`endif
  end

  // Results still inside the adder; every one of them may land in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + IF_W'(vpipe_q[i]);
    end
  end

  assign pending  = SUM_W'(count_q) + SUM_W'(inflight);
  assign issue_ok = (pending < SUM_W'(DEPTH));

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    vpipe_d    = (vpipe_q << 1) | LAT'(in_valid);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_wr, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      vpipe_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      vpipe_q    <= vpipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is not reset; out_valid gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_sum   = out_valid ? head.sum : '0;
  assign out_carry = out_valid & head.carry;
  assign count     = count_q;
  assign overflow  = overflow_q;
`ifdef RD_RESULT_PARITY_EN
  assign out_parity = out_valid & head.parity;
`endif

endmodule
